cpu_bus_responder: RTL
======================

CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

Interface
REQ-001 Parameter: RAM_AW, 11, internal work-RAM address width (2^RAM_AW bytes).
REQ-002 Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 addr  input  16  CPU bus address.
REQ-006 data  inout  8  CPU data bus; driven by this block only during mapped reads, high-Z otherwise.
REQ-007 rw_n  input  1  1 = CPU read, 0 = CPU write.
REQ-008 cpu_halt  output  1  stalls the CPU while OAM DMA runs.
REQ-009 ppu_cs  output  1  PPU register window selected.
REQ-010 ppu_we  output  1  PPU register write strobe.
REQ-011 ppu_reg  output  3  PPU register index.
REQ-012 ppu_wdata  output  8  PPU write data.
REQ-013 ppu_rdata  input  8  PPU read data.
REQ-014 prg_addr  output  15  PRG ROM address.
REQ-015 prg_rdata  input  8  PRG ROM data.
REQ-016 joy1_buttons  input  8  live controller state; bit0 = A ... bit7 = Right.
REQ-017 oam_we  output  1  OAM write strobe.
REQ-018 oam_addr  output  8  OAM byte index.
REQ-019 oam_wdata  output  8  OAM write data.

Function
REQ-020 Address map: $0000-$1FFF RAM mirrored every $0800; $2000-$3FFF PPU, reg = addr[2:0]; $4014 DMA; $4016 controller; $8000-$FFFF PRG, prg_addr = addr[14:0]; all else unmapped.
REQ-021 Read path: when rw_n=1, cpu_halt=0 and addr is mapped, data is driven combinationally from RAM[addr[RAM_AW-1:0]], ppu_rdata, prg_rdata, or {7'b0100000, shift[0]} for $4016.
REQ-022 Unmapped reads, $4014 reads, all writes, and any cycle with cpu_halt=1 leave data high-Z.
REQ-023 RAM write: on the clock edge with rw_n=0 and addr in $0000-$1FFF, RAM[addr[RAM_AW-1:0]] takes data.
REQ-024 Writes to the PRG range are ignored.
REQ-025 PPU outputs are combinational from addr, rw_n and data: ppu_cs = window hit; ppu_we = hit & ~rw_n; ppu_wdata = data.
REQ-026 Controller write: a write to $4016 loads strobe <= data[0].
REQ-027 While strobe=1, shift <= joy1_buttons on every clock.
REQ-028 Controller read: each clock edge with rw_n=1, addr=$4016, strobe=0 and cpu_halt=0 does shift <= {1'b1, shift[7:1]}.
REQ-029 After 8 reads, every further read returns bit 1.
REQ-030 DMA FSM states: IDLE, ALIGN, RD, WR.
REQ-031 IDLE->ALIGN on a write to $4014: latch page <= data; oam_addr <= 0; cpu_halt <= 1.
REQ-032 ALIGN->RD after exactly 1 cycle.
REQ-033 RD: latch byte <= RAM[{page, oam_addr}] with the index truncated to RAM_AW bits (pages >= $20 read the RAM mirror); RD->WR.
REQ-034 WR: oam_we=1 and oam_wdata=byte for one cycle; oam_addr increments.
REQ-035 WR->RD while the pre-increment oam_addr != 255; otherwise WR->IDLE and cpu_halt <= 0.
REQ-036 A complete DMA keeps cpu_halt=1 for exactly 513 cycles; oam_addr wraps 255->0 at completion.
REQ-037 While the FSM is not IDLE, CPU-side writes ($4014, $4016, RAM) are ignored.
REQ-038 oam_we is 0 in every state except WR.

Reset
REQ-039 rst_n low forces, asynchronously: FSM=IDLE, cpu_halt=0, oam_we=0, oam_addr=0, oam_wdata=0, page=0, strobe=0, shift=8'hFF.
REQ-040 RAM contents are not reset.
REQ-041 Reset asserted mid-DMA aborts the transfer immediately; no further oam_we pulses occur after rst_n rises.

Verification
REQ-042 Write $55 to $0123, then read $0923 and $1923 -> data=$55 both times; read $5000 -> data high-Z.
REQ-043 Write 1 then 0 to $4016 with joy1_buttons=$A5, then 10 reads of $4016 -> bit0 sequence 1,0,1,0,0,1,0,1,1,1.
REQ-044 Fill RAM $0200-$02FF with i^$3C, then write $02 to $4014 -> cpu_halt high for 513 cycles, 256 oam_we pulses with oam_addr 0..255 and oam_wdata=i^$3C, final oam_addr=0.
REQ-045 Pull rst_n low at DMA pulse 100 -> cpu_halt=0 and oam_we=0 immediately; zero further pulses.
REQ-046 Write $80 to $2000 and read $3FFA with ppu_rdata=$C3 -> first access ppu_we=1, ppu_reg=0, ppu_wdata=$80; second access ppu_reg=2, data=$C3.
REQ-047 Read $FFFC with prg_rdata=$9A -> prg_addr=$7FFC, data=$9A.

Source files
------------

// File: rtl/cpu_bus_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cpu_bus_responder                                      |
// | Description : CPU-side address decoder with mirrored work RAM, PPU   |
// |               register window, PRG ROM window, serial controller     |
// |               port at $4016 and a 256-byte OAM DMA engine at $4014.  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module cpu_bus_responder #(
  parameter int RAM_AW = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  inout  wire  [7:0]  data,
  input  logic        rw_n,
  output logic        cpu_halt,
  output logic        ppu_cs,
  output logic        ppu_we,
  output logic [2:0]  ppu_reg,
  output logic [7:0]  ppu_wdata,
  input  logic [7:0]  ppu_rdata,
  output logic [14:0] prg_addr,
  input  logic [7:0]  prg_rdata,
  input  logic [7:0]  joy1_buttons,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata
);

  localparam int RAM_DEPTH = 1 << RAM_AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RD    = 2'd2,
    WR    = 2'd3
  } dma_state_t;

  dma_state_t          state;
  logic [7:0]          page;
  logic                strobe;
  logic [7:0]          shift;
  logic [7:0]          ram [RAM_DEPTH];

  logic                ram_hit;
  logic                ppu_hit;
  logic                dma_hit;
  logic                joy_hit;
  logic                prg_hit;
  logic                cpu_wr;
  logic [RAM_AW-1:0]   ram_idx;
  logic [RAM_AW-1:0]   dma_idx;
  logic                rd_drive;
  logic [7:0]          rd_val;

  // Address window decode
  assign ram_hit = (addr[15:13] == 3'b000);
  assign ppu_hit = (addr[15:13] == 3'b001);
  assign dma_hit = (addr == 16'h4014);
  assign joy_hit = (addr == 16'h4016);
  assign prg_hit = addr[15];

  // CPU writes only take effect while the DMA engine is idle
  assign cpu_wr  = ~rw_n && (state == IDLE);

  // RAM is mirrored: only the low RAM_AW address bits select a byte;
  // DMA pages above the RAM size fold onto the mirror the same way
  assign ram_idx = addr[RAM_AW-1:0];
  assign dma_idx = RAM_AW'({page, oam_addr});

  assign ppu_cs    = ppu_hit;
  assign ppu_we    = ppu_hit & ~rw_n;
  assign ppu_reg   = addr[2:0];
  assign ppu_wdata = data;
  assign prg_addr  = addr[14:0];

  // Read-data mux; the bus is only driven for mapped reads while the CPU runs
  always_comb begin
    rd_drive = 1'b0;
    rd_val   = 8'h00;
    if (rw_n && !cpu_halt) begin
      if (ram_hit) begin
        rd_drive = 1'b1;
        rd_val   = ram[ram_idx];
      end else if (ppu_hit) begin
        rd_drive = 1'b1;
        rd_val   = ppu_rdata;
      end else if (joy_hit) begin
        rd_drive = 1'b1;
        rd_val   = {7'b0100000, shift[0]};
      end else if (prg_hit) begin
        rd_drive = 1'b1;
        rd_val   = prg_rdata;
      end
    end
  end

  assign data = rd_drive ? rd_val : 8'bzzzz_zzzz;

  // Work RAM write port (contents intentionally survive reset)
  always_ff @(posedge clk) begin
    if (cpu_wr && ram_hit) begin
      ram[ram_idx] <= data;
    end
  end

  // Controller latch: strobe high reloads the shifter, reads shift in ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe <= 1'b0;
      shift  <= 8'hFF;
    end else begin
      if (cpu_wr && joy_hit) begin
        strobe <= data[0];
      end
      if (strobe) begin
        shift <= joy1_buttons;
      end else if (rw_n && joy_hit && !cpu_halt) begin
        shift <= {1'b1, shift[7:1]};
      end
    end
  end

  // OAM DMA engine: one alignment cycle, then 256 read/write pairs;
  // oam_wdata doubles as the byte latch filled in RD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cpu_halt  <= 1'b0;
      oam_we    <= 1'b0;
      oam_addr  <= 8'h00;
      oam_wdata <= 8'h00;
      page      <= 8'h00;
    end else begin
      oam_we <= 1'b0;
      case (state)
        IDLE: begin
          if (!rw_n && dma_hit) begin
            page     <= data;
            oam_addr <= 8'h00;
            cpu_halt <= 1'b1;
            state    <= ALIGN;
          end
        end
        ALIGN: begin
          state <= RD;
        end
        RD: begin
          oam_wdata <= ram[dma_idx];
          oam_we    <= 1'b1;
          state     <= WR;
        end
        WR: begin
          oam_addr <= oam_addr + 8'd1;
          if (oam_addr == 8'hFF) begin
            cpu_halt <= 1'b0;
            state    <= IDLE;
          end else begin
            state <= RD;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
